load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_TOP, default 32'h3ffc, meaning byte address of highest data-memory word.
REQ-002 SHALL have parameter MEM_WORDS, default 1024, meaning data-memory depth in 32-bit words.
REQ-003 SHALL have one clock and asynchronous active-high reset: clk  in  1  rising-edge clock; reset  in  1  async active-high reset.
REQ-004 SHALL have ports: ReqValid  in  1  request strobe; ReqWrite  in  1  1=store, 0=load; ReqSize  in  2  00 byte, 01 half, 10 word, 11 reserved; ReqSigned  in  1  sign-extend load.
REQ-005 SHALL have ports: Addr  in  32  byte address; DataIn  in  32  store data, right-justified.
REQ-006 SHALL have ports: Busy  out  1  unit not idle; Done  out  1  one-cycle completion pulse; Error  out  1  qualified by Done; DataOut  out  32  load result.
REQ-007 SHALL have memory-side ports: MemAddr  out  32  word-aligned address; MemWE  out  1  write enable; MemDataIn  out  32  write word; MemDataOut  in  32  combinational read word.

Function
REQ-008 SHALL implement FSM states IDLE, LOAD, RMW_READ, WRITE, RESP; Busy = (state != IDLE).
REQ-009 SHALL accept a request only when ReqValid=1 in IDLE, latching ReqWrite, ReqSize, ReqSigned, Addr, DataIn on that edge; ReqValid outside IDLE SHALL be ignored.
REQ-010 SHALL flag error when: ReqSize=11; half access with Addr[0]=1; word access with Addr[1:0]!=0; Addr < MEM_TOP-4*(MEM_WORDS-1) or Addr > MEM_TOP+3.
REQ-011 Errored request SHALL go IDLE->RESP, assert Done and Error together one cycle after accept, never assert MemWE, leave DataOut unchanged.
REQ-012 Load SHALL go IDLE->LOAD->RESP; in LOAD capture MemDataOut, extract lane, extend, register into DataOut; Done two cycles after accept with DataOut already valid.
REQ-013 Word store SHALL go IDLE->WRITE->RESP; MemWE=1 for exactly the WRITE cycle with MemDataIn=latched DataIn; Done two cycles after accept.
REQ-014 Byte/half store SHALL go IDLE->RMW_READ->WRITE->RESP; RMW_READ captures MemDataOut; WRITE drives captured word with only the addressed lane(s) replaced by DataIn[7:0]/[15:0]; Done three cycles after accept.
REQ-015 Byte lanes SHALL be little-endian: Addr[1:0]=0 selects bits 7:0, 3 selects bits 31:24; half at Addr[1]=0 selects bits 15:0, else 31:16.
REQ-016 Sub-word loads SHALL sign-extend from lane MSB when ReqSigned=1, else zero-extend; ReqSigned ignored for word loads and stores.
REQ-017 MemAddr SHALL equal latched Addr with bits 1:0 forced to 0 in every non-IDLE state and hold its last value in IDLE.
REQ-018 MemWE SHALL be 1 only in WRITE; RESP SHALL always return to IDLE next cycle; back-to-back requests SHALL have one IDLE cycle between Done and next accept.
REQ-019 DataOut SHALL change only on successful load completion; stores SHALL not modify it.

Reset
REQ-020 On reset assertion, state SHALL go to IDLE immediately (asynchronously); Busy, Done, Error, MemWE SHALL be 0; DataOut, MemAddr, MemDataIn SHALL be 0.
REQ-021 Reset mid-operation SHALL abandon the request with no MemWE pulse afterward; a store in RMW_READ SHALL not be written.
REQ-022 First request SHALL be accepted on the first rising clk edge after reset deasserts.

Verification
REQ-023 Word store Addr=0x3ffc, DataIn=0xdeadbeef -> MemWE one cycle, MemAddr=0x3ffc, MemDataIn=0xdeadbeef; Done 2 cycles after accept, Error=0.
REQ-024 Memory word 0x3ffc=0xdeadbeef; byte store Addr=0x3ffd, DataIn=0x00000011 -> MemDataIn=0xdead11ef in WRITE; Done 3 cycles after accept.
REQ-025 Word 0x3ff8=0x8000f0a5; signed byte load 0x3ff8 -> DataOut=0xffffffa5; unsigned half load 0x3ffa -> 0x00008000; signed half load 0x3ffa -> 0xffff8000.
REQ-026 Half load Addr=0x3ff9, word store Addr=0x3ffe, load Addr=0x4000, load Addr=0x2ffc, ReqSize=11 -> each Done+Error 1 cycle after accept, MemWE never 1, DataOut unchanged.
REQ-027 Assert reset during RMW_READ of byte store to 0x3ff4 -> Busy=0 immediately, MemWE stays 0, word 0x3ff4 unchanged; next request after release completes normally.
REQ-028 ReqValid held high with two queued loads -> second accepted only after RESP->IDLE; ReqValid pulses while Busy=1 produce no extra Done.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between a simple request port and a single-word, combinationally read data memory.
// Handles byte, half and word accesses; sub-word stores are done as a read-modify-write of the containing word.
module load_store_unit #(
  parameter logic [31:0] MEM_TOP   = 32'h3ffc,
  parameter int          MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReqValid,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [31:0] Addr,
  input  logic [31:0] DataIn,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [31:0] DataOut,
  output logic [31:0] MemAddr,
  output logic        MemWE,
  output logic [31:0] MemDataIn,
  input  logic [31:0] MemDataOut
);

  localparam logic [31:0] ADDR_LO = MEM_TOP - 32'(4 * (MEM_WORDS - 1));
  localparam logic [31:0] ADDR_HI = MEM_TOP + 32'd3;

  typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [15:0] din_q;
  logic        err_q;
  logic [31:0] data_out_q;
  logic [31:0] mem_wdata_q;

  logic        accept;
  logic        req_err;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign accept  = (state_q == IDLE) && ReqValid;
  assign req_err = (ReqSize == 2'b11)
                 || ((ReqSize == 2'b01) && Addr[0])
                 || ((ReqSize == 2'b10) && (Addr[1:0] != 2'b00))
                 || (Addr < ADDR_LO) || (Addr > ADDR_HI);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ReqValid) begin
          if (req_err)                state_d = RESP;
          else if (!ReqWrite)         state_d = LOAD;
          else if (ReqSize == 2'b10)  state_d = WRITE;
          else                        state_d = RMW_READ;
        end
      end
      LOAD:     state_d = RESP;
      RMW_READ: state_d = WRITE;
      WRITE:    state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Little-endian lane selection for loads, then sign/zero extension.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_b = MemDataOut[7:0];
      2'd1:    lane_b = MemDataOut[15:8];
      2'd2:    lane_b = MemDataOut[23:16];
      default: lane_b = MemDataOut[31:24];
    endcase
    lane_h = addr_q[1] ? MemDataOut[31:16] : MemDataOut[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & lane_b[7]}}, lane_b};
      2'b01:   load_ext = {{16{signed_q & lane_h[15]}}, lane_h};
      default: load_ext = MemDataOut;
    endcase
  end

  always_comb begin
    merged = MemDataOut;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = din_q[7:0];
        2'd1:    merged[15:8]  = din_q[7:0];
        2'd2:    merged[23:16] = din_q[7:0];
        default: merged[31:24] = din_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = din_q;
    end else begin
      merged[15:0] = din_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      addr_q      <= 32'd0;
      din_q       <= 16'd0;
      err_q       <= 1'b0;
      data_out_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        size_q   <= ReqSize;
        signed_q <= ReqSigned;
        addr_q   <= Addr;
        din_q    <= DataIn[15:0];
        err_q    <= req_err;
        if (!req_err && ReqWrite && (ReqSize == 2'b10))
          mem_wdata_q <= DataIn;
      end
      if (state_q == LOAD)
        data_out_q <= load_ext;
      // The write word is fixed at the end of RMW_READ so WRITE drives a stable value.
      if (state_q == RMW_READ)
        mem_wdata_q <= merged;
    end
  end

  assign Busy      = (state_q != IDLE);
  assign Done      = (state_q == RESP);
  assign Error     = (state_q == RESP) && err_q;
  assign MemWE     = (state_q == WRITE);
  assign MemAddr   = {addr_q[31:2], 2'b00};
  assign MemDataIn = mem_wdata_q;
  assign DataOut   = data_out_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural data memory behind the memory port.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_data = 32'd0;
  logic        busy, done, error, mem_we;
  logic [31:0] data_out, mem_addr, mem_din, mem_dout;

  logic [31:0] mem [0:1023];
  int checks = 0;
  int errors = 0;

  int          lat, we_cnt, done_cnt, first_done, second_done;
  logic        err_seen;
  logic [31:0] wdata_seen, waddr_seen;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .ReqValid(req_valid), .ReqWrite(req_write), .ReqSize(req_size), .ReqSigned(req_signed),
    .Addr(req_addr), .DataIn(req_data),
    .Busy(busy), .Done(done), .Error(error), .DataOut(data_out),
    .MemAddr(mem_addr), .MemWE(mem_we), .MemDataIn(mem_din), .MemDataOut(mem_dout)
  );

  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr[11:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_din;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request at a falling edge; it is accepted on the following rising edge.
  task automatic send(input logic wr, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] d, input bit release_rst);
    @(negedge clk);
    if (release_rst) reset = 1'b0;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_data = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Count falling edges after the accept edge until Done; latency 0 means Done never came.
  task automatic wait_done(output int l, output logic e, output int we,
                           output logic [31:0] wd, output logic [31:0] wa);
    l = 0; e = 1'b0; we = 0; wd = 32'd0; wa = 32'd0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (mem_we) begin we++; wd = mem_din; wa = mem_addr; end
      if (done) begin l = n; e = error; break; end
    end
  endtask

  task automatic do_req(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d,
                        input int exp_lat, input logic exp_err, input int exp_we);
    send(wr, sz, sg, a, d, 1'b0);
    wait_done(lat, err_seen, we_cnt, wdata_seen, waddr_seen);
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".err"}, {31'd0, err_seen}, {31'd0, exp_err});
    check({tag, ".we"}, 32'(we_cnt), 32'(exp_we));
    $display("txn %s wr=%0b size=%0d addr=%h data=%h lat=%0d err=%0b we=%0d wdata=%h dout=%h",
             tag, wr, sz, a, d, lat, err_seen, we_cnt, wdata_seen, data_out);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.error", {31'd0, error}, 32'd0);
    check("rst.memwe", {31'd0, mem_we}, 32'd0);
    check("rst.dataout", data_out, 32'd0);
    check("rst.memaddr", mem_addr, 32'd0);
    check("rst.memdin", mem_din, 32'd0);
    @(negedge clk); reset = 1'b0;

    // Word store at the top word
    do_req("st_w_3ffc", 1'b1, 2'b10, 1'b0, 32'h3ffc, 32'hdeadbeef, 2, 1'b0, 1);
    check("st_w_3ffc.wdata", wdata_seen, 32'hdeadbeef);
    check("st_w_3ffc.waddr", waddr_seen, 32'h3ffc);
    check("st_w_3ffc.dout", data_out, 32'd0);

    // Byte store read-modify-write
    do_req("st_b_3ffd", 1'b1, 2'b00, 1'b0, 32'h3ffd, 32'h00000011, 3, 1'b0, 1);
    check("st_b_3ffd.wdata", wdata_seen, 32'hdead11ef);
    check("st_b_3ffd.waddr", waddr_seen, 32'h3ffc);
    check("st_b_3ffd.mem", mem[10'h3ff], 32'hdead11ef);

    // Loads with lane extraction and extension
    do_req("st_w_3ff8", 1'b1, 2'b10, 1'b0, 32'h3ff8, 32'h8000f0a5, 2, 1'b0, 1);
    do_req("ld_bs_3ff8", 1'b0, 2'b00, 1'b1, 32'h3ff8, 32'd0, 2, 1'b0, 0);
    check("ld_bs_3ff8.dout", data_out, 32'hffffffa5);
    do_req("ld_hu_3ffa", 1'b0, 2'b01, 1'b0, 32'h3ffa, 32'd0, 2, 1'b0, 0);
    check("ld_hu_3ffa.dout", data_out, 32'h00008000);
    do_req("ld_hs_3ffa", 1'b0, 2'b01, 1'b1, 32'h3ffa, 32'd0, 2, 1'b0, 0);
    check("ld_hs_3ffa.dout", data_out, 32'hffff8000);
    do_req("ld_bu_3ff9", 1'b0, 2'b00, 1'b0, 32'h3ff9, 32'd0, 2, 1'b0, 0);
    check("ld_bu_3ff9.dout", data_out, 32'h000000f0);
    do_req("ld_ws_3ffc", 1'b0, 2'b10, 1'b1, 32'h3ffc, 32'd0, 2, 1'b0, 0);
    check("ld_ws_3ffc.dout", data_out, 32'hdead11ef);

    // Half store into upper lane, then byte load from the highest byte
    do_req("st_h_3ffe", 1'b1, 2'b01, 1'b0, 32'h3ffe, 32'hffff1234, 3, 1'b0, 1);
    check("st_h_3ffe.wdata", wdata_seen, 32'h123411ef);
    check("st_h_3ffe.dout", data_out, 32'hdead11ef);
    do_req("ld_bs_3fff", 1'b0, 2'b00, 1'b1, 32'h3fff, 32'd0, 2, 1'b0, 0);
    check("ld_bs_3fff.dout", data_out, 32'h00000012);

    // Lowest legal word
    do_req("st_w_3000", 1'b1, 2'b10, 1'b0, 32'h3000, 32'h0000a5a5, 2, 1'b0, 1);
    do_req("ld_w_3000", 1'b0, 2'b10, 1'b0, 32'h3000, 32'd0, 2, 1'b0, 0);
    check("ld_w_3000.dout", data_out, 32'h0000a5a5);

    // Error requests: Done+Error after one cycle, no write, DataOut unchanged
    do_req("e_ld_h_3ff9", 1'b0, 2'b01, 1'b0, 32'h3ff9, 32'd0, 1, 1'b1, 0);
    do_req("e_st_w_3ffe", 1'b1, 2'b10, 1'b0, 32'h3ffe, 32'h55555555, 1, 1'b1, 0);
    do_req("e_ld_w_4000", 1'b0, 2'b10, 1'b0, 32'h4000, 32'd0, 1, 1'b1, 0);
    do_req("e_ld_w_2ffc", 1'b0, 2'b10, 1'b0, 32'h2ffc, 32'd0, 1, 1'b1, 0);
    do_req("e_size11", 1'b0, 2'b11, 1'b0, 32'h3ff8, 32'd0, 1, 1'b1, 0);
    do_req("e_st_b_2fff", 1'b1, 2'b00, 1'b0, 32'h2fff, 32'h99, 1, 1'b1, 0);
    check("err.dout", data_out, 32'h0000a5a5);
    check("err.mem3ffc", mem[10'h3ff], 32'h123411ef);

    // Reset during RMW_READ abandons the store
    do_req("st_w_3ff4", 1'b1, 2'b10, 1'b0, 32'h3ff4, 32'hcafef00d, 2, 1'b0, 1);
    send(1'b1, 2'b00, 1'b0, 32'h3ff4, 32'h00000077, 1'b0);
    @(negedge clk);
    check("rmwrst.busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("rmwrst.busy", {31'd0, busy}, 32'd0);
    we_cnt = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (mem_we) we_cnt++;
    end
    send(1'b0, 2'b10, 1'b0, 32'h3ff4, 32'd0, 1'b1);
    wait_done(lat, err_seen, we_cnt, wdata_seen, waddr_seen);
    check("rmwrst.we", 32'(we_cnt), 32'd0);
    check("rmwrst.mem", mem[10'h3fd], 32'hcafef00d);
    check("rmwrst.ld_lat", 32'(lat), 32'd2);
    check("rmwrst.ld_dout", data_out, 32'hcafef00d);
    $display("txn rmwrst reload addr=00003ff4 lat=%0d dout=%h", lat, data_out);

    // ReqValid held high: second load accepted only after RESP->IDLE
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b1; req_addr = 32'h3ff8;
    done_cnt = 0; first_done = 0; second_done = 0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (n == 3) check("hold.idle_gap", {31'd0, busy}, 32'd0);
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) first_done = n; else second_done = n;
      end
      if (n == 4) req_valid = 1'b0;
    end
    check("hold.done_cnt", 32'(done_cnt), 32'd2);
    check("hold.first", 32'(first_done), 32'd2);
    check("hold.second", 32'(second_done), 32'd5);
    check("hold.dout", data_out, 32'hffffffa5);
    $display("txn hold2 done_cnt=%0d first=%0d second=%0d dout=%h", done_cnt, first_done, second_done, data_out);

    // ReqValid pulse while busy with a word store produces no extra Done
    send(1'b1, 2'b10, 1'b0, 32'h3ff0, 32'h0badf00d, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_size = 2'b11; req_write = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    done_cnt = 0; err_seen = 1'b0;
    for (int n = 0; n < 6; n++) begin
      if (done) begin done_cnt++; err_seen = err_seen | error; end
      @(negedge clk);
    end
    check("pulse.done_cnt", 32'(done_cnt), 32'd1);
    check("pulse.err", {31'd0, err_seen}, 32'd0);
    check("pulse.mem", mem[10'h3fc], 32'h0badf00d);
    $display("txn pulse done_cnt=%0d err=%0b mem=%h", done_cnt, err_seen, mem[10'h3fc]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
